// File: rtl/poly_basemul_ctrl_pkg.sv
// Shared constants, FSM state type and modular-reduction helper for the
// Kyber polynomial basemul controller.
package poly_basemul_ctrl_pkg;

  localparam int N_PAIRS = 128;
  localparam int ADDR_W  = 7;
  localparam int COEF_W  = 12;
  localparam int PAIR_W  = 24;

  localparam logic [COEF_W-1:0] KYBER_Q   = 12'd3329;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 7'd127;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Full reduction of a non-negative 32-bit value into [0, q-1].
  function automatic logic [COEF_W-1:0] reduce_q(input logic [31:0] x);
    return 12'(x % {20'd0, KYBER_Q});
  endfunction

endpackage

// File: rtl/poly_basemul_ctrl_if.sv
// Control handshake plus coefficient/gamma memory bus of the basemul controller.
// master = the controller, slave = sequencer and memories around it.
interface poly_basemul_ctrl_if;
  import poly_basemul_ctrl_pkg::*;

  logic                start;
  logic                acc_mode;
  logic                busy;
  logic                done;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [PAIR_W-1:0]   a_rdata;
  logic [PAIR_W-1:0]   b_rdata;
  logic [COEF_W-1:0]   zeta_rdata;
  logic [PAIR_W-1:0]   c_rdata;
  logic                c_we;
  logic [ADDR_W-1:0]   c_waddr;
  logic [PAIR_W-1:0]   c_wdata;

  modport master (
    input  start, acc_mode, a_rdata, b_rdata, zeta_rdata, c_rdata,
    output busy, done, rd_en, rd_addr, c_we, c_waddr, c_wdata
  );

  modport slave (
    output start, acc_mode, a_rdata, b_rdata, zeta_rdata, c_rdata,
    input  busy, done, rd_en, rd_addr, c_we, c_waddr, c_wdata
  );

endinterface

// File: rtl/poly_basemul_ctrl_basemul.sv
// Combinational Kyber basemul of one coefficient pair:
// c0 = a0*b0 + a1*b1*gamma, c1 = a0*b1 + a1*b0, both mod q.
module basemul_unit
  import poly_basemul_ctrl_pkg::*;
(
  input  logic [PAIR_W-1:0] a,
  input  logic [PAIR_W-1:0] b,
  input  logic [COEF_W-1:0] zeta,
  output logic [COEF_W-1:0] c0,
  output logic [COEF_W-1:0] c1
);

  logic [31:0] a0_s;
  logic [31:0] a1_s;
  logic [31:0] b0_s;
  logic [31:0] b1_s;
  logic [31:0] g_s;
  logic [31:0] hi_s;

  assign a0_s = {20'd0, a[11:0]};
  assign a1_s = {20'd0, a[23:12]};
  assign b0_s = {20'd0, b[11:0]};
  assign b1_s = {20'd0, b[23:12]};
  assign g_s  = {20'd0, zeta};

  // a1*b1 is reduced before the gamma multiply so every sum stays below 2^32.
  assign hi_s = {20'd0, reduce_q(a1_s * b1_s)};
  assign c0   = reduce_q((a0_s * b0_s) + (hi_s * g_s));
  assign c1   = reduce_q((a0_s * b1_s) + (a1_s * b0_s));

endmodule

// File: rtl/poly_basemul_ctrl_mod_add_q.sv
// Modular addition of two reduced coefficients with one conditional subtract;
// the result lies in [0, q-1].
module mod_add_q
  import poly_basemul_ctrl_pkg::*;
(
  input  logic [COEF_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  output logic [COEF_W-1:0] y
);

  logic [COEF_W:0] sum_s;
  logic [COEF_W:0] diff_s;

  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = sum_s - {1'b0, KYBER_Q};

  // Select the wrapped sum once it reaches q.
  always_comb begin
    if (sum_s >= {1'b0, KYBER_Q}) begin
      y = diff_s[COEF_W-1:0];
    end else begin
      y = sum_s[COEF_W-1:0];
    end
  end

endmodule

// File: rtl/poly_basemul_ctrl.sv
// Sequences one basemul_unit over the 128 pairs of a polynomial: read at t,
// compute/accumulate at t+1, write C at t+2, one pair per cycle.
module poly_basemul_ctrl
  import poly_basemul_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  poly_basemul_ctrl_if.master  bus
);

  state_e               state_q,     state_d;
  logic                 busy_q,      busy_d;
  logic                 done_q,      done_d;
  logic                 rd_en_q,     rd_en_d;
  logic [ADDR_W-1:0]    rd_addr_q,   rd_addr_d;
  logic                 acc_q,       acc_d;
  logic                 s1_valid_q,  s1_valid_d;
  logic [ADDR_W-1:0]    s1_addr_q,   s1_addr_d;
  logic                 c_we_q,      c_we_d;
  logic [ADDR_W-1:0]   c_waddr_q,   c_waddr_d;
  logic [PAIR_W-1:0]    c_wdata_q,   c_wdata_d;

  logic [COEF_W-1:0]    c0n_s;
  logic [COEF_W-1:0]    c1n_s;
  logic [COEF_W-1:0]    c0_old_s;
  logic [COEF_W-1:0]    c1_old_s;
  logic [COEF_W-1:0]    c0_out_s;
  logic [COEF_W-1:0]    c1_out_s;

  basemul_unit u_basemul (
    .a    (bus.a_rdata),
    .b    (bus.b_rdata),
    .zeta (bus.zeta_rdata),
    .c0   (c0n_s),
    .c1   (c1n_s)
  );

  // Plain mode adds zero, so the same adders serve both modes.
  assign c0_old_s = acc_q ? bus.c_rdata[11:0]  : 12'd0;
  assign c1_old_s = acc_q ? bus.c_rdata[23:12] : 12'd0;

  mod_add_q u_add_c0 (
    .a (c0n_s),
    .b (c0_old_s),
    .y (c0_out_s)
  );

  mod_add_q u_add_c1 (
    .a (c1n_s),
    .b (c1_old_s),
    .y (c1_out_s)
  );

  // Next-state logic for the FSM, address counter and pipeline stages.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    acc_d      = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_ISSUE;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = {ADDR_W{1'b0}};
          acc_d     = bus.acc_mode;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (rd_addr_q == LAST_ADDR) begin
          state_d   = ST_DRAIN;
          rd_en_d   = 1'b0;
        end else begin
          rd_addr_d = rd_addr_q + 7'd1;
        end
      end
      ST_DRAIN: begin
        // done_q marks the final write cycle; leave once it has been seen.
        if (done_q) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
        end else begin
          state_d   = ST_DRAIN;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        rd_en_d    = 1'b0;
      end
    endcase

    s1_valid_d = rd_en_q;
    s1_addr_d  = rd_addr_q;
    c_we_d     = s1_valid_q;
    done_d     = s1_valid_q && (s1_addr_q == LAST_ADDR);

    if (s1_valid_q) begin
      c_waddr_d = s1_addr_q;
      c_wdata_d = {c1_out_s, c0_out_s};
    end else begin
      c_waddr_d = c_waddr_q;
      c_wdata_d = c_wdata_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= {ADDR_W{1'b0}};
      acc_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= {ADDR_W{1'b0}};
      c_we_q     <= 1'b0;
      c_waddr_q  <= {ADDR_W{1'b0}};
      c_wdata_q  <= {PAIR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      acc_q      <= acc_d;
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      c_we_q     <= c_we_d;
      c_waddr_q  <= c_waddr_d;
      c_wdata_q  <= c_wdata_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.c_we    = c_we_q;
  assign bus.c_waddr = c_waddr_q;
  assign bus.c_wdata = c_wdata_q;

endmodule
